// File: rtl/wb_pkg.sv
// Shared types for the command-driven strobe/ack bus master.
// The default bus widths size the command entry buffered ahead of the bus FSM.
package wb_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    typedef struct packed {
        logic              we;
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/wb_cmd_master_if.sv
// Command, response and bus signals of wb_cmd_master in one bundle.
// The master modport is the DUT view; the slave modport is the environment view.
interface wb_cmd_master_if
    import wb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_we;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          we;
    logic          strb;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ack;
    logic          busy;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, rdata, ack,
        output cmd_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err,
               we, strb, addr, wdata, busy
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, rdata, ack,
        input  cmd_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err,
               we, strb, addr, wdata, busy
    );

endinterface

// File: rtl/wb_cmd_fifo.sv
// Circular command buffer; a push becomes visible at head one cycle later (no bypass).
// A push while full is dropped even if a pop happens in the same cycle.
module wb_cmd_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = cmd_t
)(
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t data,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output entry_t head
);
    localparam int PW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      count <= count + (PW+1)'(1);
            else if (do_pop && !do_push) count <= count - (PW+1)'(1);
        end
    end

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data;
    end

endmodule

// File: rtl/wb_cmd_master.sv
// Buffers commands, runs them one at a time on the strobe/ack bus with a timeout, returns in-order responses.
// Strobe rises one cycle after the pop; a stalled response holds the FSM in RESP while the FIFO keeps filling.
module wb_cmd_master
    import wb_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
)(
    input  logic             clk,
    input  logic             rst,
    wb_cmd_master_if.master  bus
);
    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } entry_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          strb_q, strb_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_we_q, rsp_we_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic   fifo_full;
    logic   fifo_empty;
    logic   fifo_pop;
    entry_t fifo_in;
    entry_t fifo_head;

    assign fifo_in = '{we: bus.cmd_we, addr: bus.cmd_addr, wdata: bus.cmd_wdata};

    wb_cmd_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.cmd_valid),
        .data  (fifo_in),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        strb_d      = strb_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_we_d    = rsp_we_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        fifo_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    we_d     = fifo_head.we;
                    addr_d   = fifo_head.addr;
                    wdata_d  = fifo_head.wdata;
                    strb_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // Ack wins over a timeout landing in the same cycle.
                if (bus.ack) begin
                    strb_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = we_q;
                    rsp_rdata_d = we_q ? '0 : bus.rdata;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    strb_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = we_q;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                // Returning through IDLE guarantees a strobe-low cycle before the next command.
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            strb_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            strb_q      <= strb_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.cmd_ready = !fifo_full;
    assign bus.strb      = strb_q;
    assign bus.we        = we_q;
    assign bus.addr      = addr_q;
    assign bus.wdata     = wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_we    = rsp_we_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomised bench for wb_cmd_master: a memory-slave model with per-command ack timing
// and a scoreboard fed by a reference model when each command is accepted.
module tb_wb_cmd_master;
    logic clk;
    logic rst;

    wb_cmd_master_if #(.AW(8), .DW(8)) bus ();

    wb_cmd_master #(.AW(8), .DW(8), .DEPTH(4), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] exp_q[$];   // {we, rdata, err}
    int         beh_q[$];   // ack cycle per issued command, 0 = never ack
    logic [7:0] ref_mem [256];
    logic [7:0] smem    [256];
    int         ready_mode = 1;  // 0 low, 1 high, 2 random
    logic       spur_en    = 1'b0;
    logic       force_ack  = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference behaviour: commands complete in order; a write lands in memory only when acked.
    function automatic void model_accept(logic w, logic [7:0] a, logic [7:0] d, int beh);
        beh_q.push_back(beh);
        if (beh == 0) begin
            exp_q.push_back({w, 8'h00, 1'b1});
        end else if (w) begin
            ref_mem[a] = d;
            exp_q.push_back({1'b1, 8'h00, 1'b0});
        end else begin
            exp_q.push_back({1'b0, ref_mem[a], 1'b0});
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic w, input logic [7:0] a, input logic [7:0] d, input int beh);
        int n;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        forever begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                model_accept(w, a, d, beh);
                break;
            end
            n++;
            if (n > 500) begin
                chk("push_wait", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic try_push(input logic w, input logic [7:0] a, input logic [7:0] d,
                            input int beh, output logic accepted);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        @(negedge clk);
        accepted = bus.cmd_ready;
        if (accepted) model_accept(w, a, d, beh);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            tick(1);
            n++;
        end
        if (n >= 3000) chk("drain_wait", 32'(exp_q.size()), 32'd0);
        tick(3);
    endtask

    // Response consumer
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       bus.rsp_ready = 1'b0;
                1:       bus.rsp_ready = 1'b1;
                default: bus.rsp_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Memory slave: acks on the beh-th strobe cycle of each transaction
    initial begin : slave
        int         k;
        int         beh;
        logic       active;
        logic       stable;
        logic       w0;
        logic [7:0] a0;
        logic [7:0] d0;
        active = 1'b0; k = 0; beh = 1; stable = 1'b1; w0 = 1'b0; a0 = 8'h00; d0 = 8'h00;
        bus.ack = 1'b0;
        bus.rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            bus.ack   = 1'b0;
            bus.rdata = 8'($urandom);
            if (!rst) begin
                active = 1'b0;
                continue;
            end
            if (bus.strb) begin
                if (!active) begin
                    active = 1'b1; k = 0; stable = 1'b1;
                    w0 = bus.we; a0 = bus.addr; d0 = bus.wdata;
                    if (beh_q.size() != 0) beh = beh_q.pop_front();
                    else begin
                        chk("strb_unexpected", 32'd1, 32'd0);
                        beh = 1;
                    end
                end else if (bus.we !== w0 || bus.addr !== a0 || bus.wdata !== d0) begin
                    stable = 1'b0;
                end
                k++;
                if (k == beh) begin
                    bus.ack = 1'b1;
                    if (w0) smem[a0] = d0;
                    else    bus.rdata = smem[a0];
                end
            end else begin
                if (active) begin
                    chk("bus_stable", 32'(stable), 32'd1);
                    chk("strb_len", 32'(k), 32'((beh == 0) ? 16 : beh));
                end
                active = 1'b0;
                if (force_ack || (spur_en && $urandom_range(0, 7) == 0)) bus.ack = 1'b1;
            end
        end
    end

    // Scoreboard monitor
    initial begin : monitor
        int         cyc;
        int         hs_cyc;
        logic       held;
        logic       strb_prev;
        logic [9:0] held_v;
        logic [9:0] cur;
        cyc = 0; hs_cyc = -10; held = 1'b0; strb_prev = 1'b0; held_v = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                held = 1'b0;
                strb_prev = 1'b0;
                continue;
            end
            cur = {bus.rsp_we, bus.rsp_rdata, bus.rsp_err};
            if (bus.strb && !strb_prev) chk("strb_gap", 32'(cyc - hs_cyc >= 2), 32'd1);
            strb_prev = bus.strb;
            if (bus.rsp_valid) chk("strb_in_resp", 32'(bus.strb), 32'd0);
            if (held && bus.rsp_valid) chk("rsp_hold", 32'(cur), 32'(held_v));
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
                else chk("rsp", 32'(cur), 32'(exp_q.pop_front()));
                hs_cyc = cyc;
                held = 1'b0;
            end else begin
                held   = bus.rsp_valid;
                held_v = cur;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic acc;
        int   r;
        int   b;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'h00;
            smem[i]    = 8'h00;
        end
        rst = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = 8'h00; bus.cmd_wdata = 8'h00;
        tick(3);
        chk("rst_strb", 32'(bus.strb), 32'd0);
        chk("rst_we", 32'(bus.we), 32'd0);
        chk("rst_addr", 32'(bus.addr), 32'd0);
        chk("rst_wdata", 32'(bus.wdata), 32'd0);
        chk("rst_rsp", 32'({bus.rsp_valid, bus.rsp_we, bus.rsp_rdata, bus.rsp_err}), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b1;
        tick(1);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Write then read back
        push_cmd(1'b1, 8'h10, 8'hA5, 2);
        push_cmd(1'b0, 8'h10, 8'h00, 2);
        drain();

        // Timeout, then normal traffic continues
        push_cmd(1'b0, 8'h33, 8'h00, 0);
        push_cmd(1'b1, 8'h34, 8'h7E, 1);
        push_cmd(1'b0, 8'h34, 8'h00, 3);
        drain();

        // Ack on the final strobe cycle succeeds
        push_cmd(1'b1, 8'h44, 8'h5C, 1);
        push_cmd(1'b0, 8'h44, 8'h00, 16);
        drain();

        // Response backpressure
        ready_mode = 0;
        tick(2);
        push_cmd(1'b1, 8'h50, 8'h11, 1);
        push_cmd(1'b0, 8'h50, 8'h00, 1);
        tick(10);
        chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp_strb", 32'(bus.strb), 32'd0);
        chk("bp_busy", 32'(bus.busy), 32'd1);
        ready_mode = 1;
        drain();

        // FIFO full: four queued behind the one held in RESP, sixth rejected
        ready_mode = 0;
        tick(2);
        for (int i = 0; i < 6; i++) begin
            try_push(1'(i % 2), 8'(8'h20 + i), 8'(8'hC0 + i), 1 + (i % 3), acc);
            chk("full_accept", 32'(acc), 32'(i < 5));
        end
        bus.cmd_valid = 1'b0;
        tick(3);
        chk("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        ready_mode = 1;
        drain();
        chk("drained_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("drained_busy", 32'(bus.busy), 32'd0);

        // Randomised traffic with random backpressure and stray acks
        spur_en = 1'b1;
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            b = (r == 0) ? 0 : (r == 1) ? 16 : $urandom_range(1, 5);
            push_cmd(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom), b);
            if ($urandom_range(0, 3) == 0) tick(1 + $urandom_range(0, 4));
        end
        drain();
        spur_en = 1'b0;
        ready_mode = 1;
        tick(2);

        // Asynchronous reset while strobe is high
        push_cmd(1'b0, 8'h60, 8'h00, 0);
        r = 0;
        while (!bus.strb && r < 20) begin
            tick(1);
            r++;
        end
        chk("pre_rst_strb", 32'(bus.strb), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_strb", 32'(bus.strb), 32'd0);
        chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        exp_q.delete();
        beh_q.delete();
        tick(2);
        rst = 1'b1;
        tick(1);
        chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        force_ack = 1'b1;
        tick(2);
        force_ack = 1'b0;
        tick(4);
        chk("late_ack_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("late_ack_strb", 32'(bus.strb), 32'd0);

        // Normal operation after reset
        push_cmd(1'b0, 8'h10, 8'h00, 2);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
